// File: rtl/match_window_counter.sv
// Counts detector match pulses over fixed WINDOW_LEN-cycle windows and hands each
// window total to the readout logic over valid/ready, holding one pending report.
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   EMPTY   | no report pending; report_valid=0
//   FULL    | one report pending, not yet accepted
//   OVERRUN | pending report was replaced by a newer window before acceptance
module match_window_counter #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_BITS   = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                det_in,
    input  logic                clear,
    input  logic                report_ready,
    output logic                report_valid,
    output logic [CNT_BITS-1:0] report_count,
    output logic                report_overrun
);

    localparam int                 CW         = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [CW-1:0]       LAST_CYCLE = CW'(WINDOW_LEN - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

    // Encoding is {report_valid, report_overrun} so the outputs come straight off the flops.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        FULL    = 2'b10,
        OVERRUN = 2'b11
    } rpt_state_t;

    rpt_state_t          state;
    logic [CW-1:0]       cycle_cnt;
    logic [CNT_BITS-1:0] acc;
    logic [CNT_BITS-1:0] acc_sum;
    logic                window_close;

    always_comb begin
        acc_sum = (acc == CNT_MAX) ? acc : acc + CNT_BITS'(det_in);
    end

    assign window_close   = (cycle_cnt == LAST_CYCLE);
    assign report_valid   = state[1];
    assign report_overrun = state[0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cycle_cnt    <= '0;
            acc          <= '0;
            report_count <= '0;
            state        <= EMPTY;
        end else if (clear) begin
            cycle_cnt    <= '0;
            acc          <= '0;
            report_count <= '0;
            state        <= EMPTY;
        end else begin
            // The closing cycle's det_in is folded into the reported total.
            if (window_close) begin
                cycle_cnt    <= '0;
                acc          <= '0;
                report_count <= acc_sum;
            end else begin
                cycle_cnt <= cycle_cnt + CW'(1);
                acc       <= acc_sum;
            end

            case (state)
                EMPTY: begin
                    if (window_close) state <= FULL;
                end
                FULL, OVERRUN: begin
                    if (window_close)
                        state <= report_ready ? FULL : OVERRUN;
                    else if (report_ready)
                        state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_match_window_counter.sv
// Scoreboard bench for match_window_counter: each window's expected report is queued
// when its stimulus is driven and popped on the edge that closes the window.
`timescale 1ns/1ps
module tb_match_window_counter;

    localparam int WIN = 16;

    typedef struct {
        int unsigned cnt;
        bit          ovr;
    } rpt_t;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       det_in;
    logic       clear;
    logic       report_ready;
    logic       report_valid;
    logic [7:0] report_count;
    logic       report_overrun;
    logic       sat_valid;
    logic [2:0] sat_count;
    logic       sat_overrun;

    int   n_checks = 0;
    int   n_errors = 0;
    int   win_pos  = 0;
    rpt_t sb_q[$];

    logic [WIN-1:0] v_hist;
    logic [WIN-1:0] o_hist;
    logic [7:0]     c_hist[WIN];
    logic [2:0]     sat_at_close;

    always #1.25 tb_clk = ~tb_clk;

    match_window_counter #(.WINDOW_LEN(16), .CNT_BITS(8)) dut (
        .clk            (tb_clk),
        .n_rst          (n_rst),
        .det_in         (det_in),
        .clear          (clear),
        .report_ready   (report_ready),
        .report_valid   (report_valid),
        .report_count   (report_count),
        .report_overrun (report_overrun)
    );

    match_window_counter #(.WINDOW_LEN(16), .CNT_BITS(3)) dut_sat (
        .clk            (tb_clk),
        .n_rst          (n_rst),
        .det_in         (det_in),
        .clear          (clear),
        .report_ready   (report_ready),
        .report_valid   (sat_valid),
        .report_count   (sat_count),
        .report_overrun (sat_overrun)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, let the posedge happen, return at the next negedge.
    task automatic drive_cycle(input logic d, input logic r, input logic c);
        rpt_t exp;
        det_in       = d;
        report_ready = r;
        clear        = c;
        @(negedge tb_clk);
        if (c) begin
            win_pos = 0;
        end else begin
            win_pos++;
            if (win_pos == WIN) begin
                win_pos      = 0;
                sat_at_close = sat_count;
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 1, 0);
                end else begin
                    exp = sb_q.pop_front();
                    check_eq("close_valid", report_valid, 1);
                    check_eq("close_count", report_count, exp.cnt);
                    check_eq("close_ovr", report_overrun, exp.ovr);
                end
            end
        end
    endtask

    task automatic run_window(input logic [WIN-1:0] det_pat, input logic [WIN-1:0] rdy_pat,
                              input int unsigned exp_cnt, input bit exp_ovr);
        rpt_t e;
        e.cnt = exp_cnt;
        e.ovr = exp_ovr;
        sb_q.push_back(e);
        for (int i = 0; i < WIN; i++) begin
            drive_cycle(det_pat[i], rdy_pat[i], 1'b0);
            v_hist[i] = report_valid;
            o_hist[i] = report_overrun;
            c_hist[i] = report_count;
        end
    endtask

    initial begin
        n_rst        = 1'b0;
        det_in       = 1'b0;
        clear        = 1'b0;
        report_ready = 1'b0;
        repeat (3) @(negedge tb_clk);
        check_eq("rst_valid", report_valid, 0);
        check_eq("rst_count", report_count, 0);
        check_eq("rst_ovr", report_overrun, 0);
        n_rst   = 1'b1;
        win_pos = 0;

        // Pulses on cycles 3,6,9 with ready held high; report lasts one cycle.
        run_window(16'h0248, 16'hFFFF, 3, 0);
        check_eq("t2_no_early_valid", v_hist[14], 0);
        check_eq("t2_sat_count", sat_at_close, 3);
        run_window(16'h0000, 16'hFFFF, 0, 0);
        check_eq("t2_valid_one_cycle", v_hist[0], 0);

        // Back-pressure: A=2 pulses, B=5 pulses overwrites A and flags overrun.
        run_window(16'h0404, 16'h0001, 2, 0);
        run_window(16'h02AA, 16'h0000, 5, 1);
        check_eq("t3_hold_count", c_hist[14], 2);
        check_eq("t3_hold_ovr", o_hist[14], 0);
        run_window(16'h0000, 16'h0001, 0, 0);
        check_eq("t3_accept_valid", v_hist[0], 0);
        check_eq("t3_accept_ovr", o_hist[0], 0);

        // Accept on the same edge as the next close: fresh report, no overrun.
        run_window(16'h8821, 16'h8000, 4, 0);
        check_eq("t5_pending_valid", v_hist[14], 1);
        check_eq("t5_pending_count", c_hist[14], 0);

        // All-ones window: 16 on the 8-bit counter, clamps to 7 on the 3-bit one.
        run_window(16'hFFFF, 16'hFFFF, 16, 0);
        check_eq("t4_sat_count", sat_at_close, 7);

        // Clear at cycle 8 with a report pending; det_in on the clear edge is dropped.
        for (int i = 0; i < 8; i++) drive_cycle((i == 2 || i == 5), 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1);
        check_eq("t6_clr_valid", report_valid, 0);
        check_eq("t6_clr_count", report_count, 0);
        check_eq("t6_clr_ovr", report_overrun, 0);
        run_window(16'h0012, 16'h0000, 2, 0);

        // Async reset mid-window with a report pending clears outputs before any edge.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0);
        det_in = 1'b0;
        n_rst  = 1'b0;
        #0.5;
        check_eq("t1_async_valid", report_valid, 0);
        check_eq("t1_async_count", report_count, 0);
        check_eq("t1_async_ovr", report_overrun, 0);
        @(negedge tb_clk);
        @(negedge tb_clk);
        n_rst   = 1'b1;
        win_pos = 0;
        run_window(16'h8000, 16'h0000, 1, 0);
        check_eq("t1_no_early_valid", v_hist[14], 0);

        check_eq("sb_leftover", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
